// File: rtl/ours_jtag_req_arb.sv
// Round-robin arbiter sharing one JTAG request engine among N_REQ requesters, one read outstanding.
// Optional read-response timeout: define OURS_JTAG_REQ_ARB_TIMEOUT_EN.
module ours_jtag_req_arb #(
    parameter int N_REQ       = 2,
    parameter int JTAG_OP_W   = 2,
    parameter int JTAG_ADDR_W = 40,
    parameter int JTAG_DATA_W = 64,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [N_REQ-1:0]               req_vld,
    output logic [N_REQ-1:0]               req_rdy,
    input  logic [N_REQ*JTAG_OP_W-1:0]     req_op,
    input  logic [N_REQ*JTAG_ADDR_W-1:0]   req_addr,
    input  logic [N_REQ*JTAG_DATA_W-1:0]   req_data,
    output logic [N_REQ-1:0]               rd_resp_vld,
    input  logic [N_REQ-1:0]               rd_resp_rdy,
    output logic [JTAG_DATA_W-1:0]         rd_resp_data,
    output logic                           rd_resp_err,
    output logic                           jtag_req_vld,
    input  logic                           jtag_req_rdy,
    output logic [JTAG_OP_W-1:0]           jtag_req_op,
    output logic [JTAG_ADDR_W-1:0]         jtag_req_addr,
    output logic [JTAG_DATA_W-1:0]         jtag_req_data,
    input  logic                           jtag_rd_resp_vld,
    output logic                           jtag_rd_resp_rdy,
    input  logic [JTAG_DATA_W-1:0]         jtag_rd_resp_data,
    output logic                           busy,
    output logic [$clog2(N_REQ)-1:0]       owner,
    output logic                           stray_resp
);
    localparam int IDX_W = $clog2(N_REQ);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RESP} state_t;

    state_t           state, state_nxt;
    logic [IDX_W-1:0] rr_ptr, win;
    logic             any_vld, accept, resp_hs, timed_out;

    // First valid requester at or after rr_ptr, wrapping.
    always_comb begin
        win     = '0;
        any_vld = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!any_vld && req_vld[(int'(rr_ptr) + k) % N_REQ]) begin
                any_vld = 1'b1;
                win     = IDX_W'((int'(rr_ptr) + k) % N_REQ);
            end
        end
    end

    assign accept       = (state == IDLE) && any_vld;
    assign busy         = (state != IDLE);
    assign jtag_req_vld = (state == ISSUE);

`ifdef OURS_JTAG_REQ_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC);
    logic [CNT_W-1:0] wait_cnt;

    // Held at zero outside WAIT_RESP so every read starts a fresh count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt  <= '0;
            timed_out <= 1'b0;
        end else if (state != WAIT_RESP) begin
            wait_cnt  <= '0;
            timed_out <= 1'b0;
        end else if (!timed_out && !resp_hs) begin
            if (wait_cnt == CNT_W'(TIMEOUT_CYC - 1))
                timed_out <= 1'b1;
            wait_cnt <= wait_cnt + 1'b1;
        end
    end
`else
    assign timed_out = 1'b0;
`endif

    always_comb begin
        state_nxt        = state;
        req_rdy          = '0;
        rd_resp_vld      = '0;
        rd_resp_data     = jtag_rd_resp_data;
        rd_resp_err      = 1'b0;
        jtag_rd_resp_rdy = 1'b1;
        resp_hs          = 1'b0;
        case (state)
            IDLE: begin
                if (any_vld) begin
                    req_rdy[win] = 1'b1;
                    state_nxt    = ISSUE;
                end
            end
            ISSUE: begin
                if (jtag_req_rdy)
                    state_nxt = jtag_req_op[0] ? IDLE : WAIT_RESP;
            end
            WAIT_RESP: begin
                if (timed_out) begin
                    // Synthetic error response; engine is back-pressured so a late reply lands as stray.
                    rd_resp_vld[owner] = 1'b1;
                    rd_resp_err        = 1'b1;
                    rd_resp_data       = '0;
                    jtag_rd_resp_rdy   = 1'b0;
                    if (rd_resp_rdy[owner])
                        state_nxt = IDLE;
                end else begin
                    rd_resp_vld[owner] = jtag_rd_resp_vld;
                    jtag_rd_resp_rdy   = rd_resp_rdy[owner];
                    resp_hs            = jtag_rd_resp_vld & rd_resp_rdy[owner];
                    if (resp_hs)
                        state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            rr_ptr        <= '0;
            owner         <= '0;
            jtag_req_op   <= '0;
            jtag_req_addr <= '0;
            jtag_req_data <= '0;
            stray_resp    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                owner         <= win;
                rr_ptr        <= (int'(win) == N_REQ - 1) ? '0 : win + 1'b1;
                jtag_req_op   <= req_op[int'(win)*JTAG_OP_W +: JTAG_OP_W];
                jtag_req_addr <= req_addr[int'(win)*JTAG_ADDR_W +: JTAG_ADDR_W];
                jtag_req_data <= req_data[int'(win)*JTAG_DATA_W +: JTAG_DATA_W];
            end
            if (jtag_rd_resp_vld && state != WAIT_RESP)
                stray_resp <= 1'b1;
        end
    end
endmodule

// File: tb/tb_ours_jtag_req_arb.sv
// Bench for ours_jtag_req_arb: directed test-plan steps, then random traffic against a behavioural model.
module tb_ours_jtag_req_arb;
    localparam int N = 2, OPW = 2, AW = 40, DW = 64, TO = 8;
`ifdef OURS_JTAG_REQ_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic                   clk = 1'b0, rst;
    logic [N-1:0]           req_vld, req_rdy, rd_resp_vld, rd_resp_rdy;
    logic [N*OPW-1:0]       req_op;
    logic [N*AW-1:0]        req_addr;
    logic [N*DW-1:0]        req_data;
    logic [DW-1:0]          rd_resp_data, jtag_rd_resp_data, jtag_req_data;
    logic                   rd_resp_err, jtag_req_vld, jtag_req_rdy;
    logic [OPW-1:0]         jtag_req_op;
    logic [AW-1:0]          jtag_req_addr;
    logic                   jtag_rd_resp_vld, jtag_rd_resp_rdy, busy, stray_resp;
    logic [$clog2(N)-1:0]   owner;

    int passed = 0, total = 0;

    // reference-model state
    int             m_phase, m_ptr, m_owner, m_wcnt, win;
    bit             m_to, m_stray;
    logic [OPW-1:0] m_op;
    logic [AW-1:0]  m_addr;
    logic [DW-1:0]  m_data;
    bit             pend [N];
    logic [OPW-1:0] p_op [N];
    logic [AW-1:0]  p_addr [N];
    logic [DW-1:0]  p_data [N];
    logic [N-1:0]   e_rdy, e_rvld;
    logic [DW-1:0]  e_rdata;
    logic           e_jrdy, e_err;

    ours_jtag_req_arb #(.N_REQ(N), .JTAG_OP_W(OPW), .JTAG_ADDR_W(AW), .JTAG_DATA_W(DW),
                        .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst), .req_vld(req_vld), .req_rdy(req_rdy), .req_op(req_op),
        .req_addr(req_addr), .req_data(req_data), .rd_resp_vld(rd_resp_vld),
        .rd_resp_rdy(rd_resp_rdy), .rd_resp_data(rd_resp_data), .rd_resp_err(rd_resp_err),
        .jtag_req_vld(jtag_req_vld), .jtag_req_rdy(jtag_req_rdy), .jtag_req_op(jtag_req_op),
        .jtag_req_addr(jtag_req_addr), .jtag_req_data(jtag_req_data),
        .jtag_rd_resp_vld(jtag_rd_resp_vld), .jtag_rd_resp_rdy(jtag_rd_resp_rdy),
        .jtag_rd_resp_data(jtag_rd_resp_data), .busy(busy), .owner(owner),
        .stray_resp(stray_resp));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %h, want %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic [OPW-1:0] op,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_vld[i]             = v;
        req_op[i*OPW +: OPW]   = op;
        req_addr[i*AW +: AW]   = a;
        req_data[i*DW +: DW]   = d;
    endtask

    initial begin
        rst = 1'b1; req_vld = '0; req_op = '0; req_addr = '0; req_data = '0;
        rd_resp_rdy = '0; jtag_req_rdy = 1'b0; jtag_rd_resp_vld = 1'b0; jtag_rd_resp_data = '0;
        tick(); tick();
        rst = 1'b0;
        #2;
        // reset values
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_jvld", 64'(jtag_req_vld), 64'd0);
        chk("rst_jaddr", 64'(jtag_req_addr), 64'd0);
        chk("rst_jdata", jtag_req_data, 64'd0);
        chk("rst_jop", 64'(jtag_req_op), 64'd0);
        chk("rst_owner", 64'(owner), 64'd0);
        chk("rst_stray", 64'(stray_resp), 64'd0);
        chk("rst_err", 64'(rd_resp_err), 64'd0);
        chk("rst_rvld", 64'(rd_resp_vld), 64'd0);
        chk("rst_rdy", 64'(req_rdy), 64'd0);
        tick();

        // simultaneous writes
        set_req(0, 1'b1, 2'b01, 40'h10, 64'hA0);
        set_req(1, 1'b1, 2'b01, 40'h20, 64'hB0);
        jtag_req_rdy = 1'b1;
        #2; chk("sw_c0_rdy", 64'(req_rdy), 64'b01); chk("sw_c0_jvld", 64'(jtag_req_vld), 64'd0);
        tick(); req_vld[0] = 1'b0;
        #2; chk("sw_c1_rdy", 64'(req_rdy), 64'b00); chk("sw_c1_jvld", 64'(jtag_req_vld), 64'd1);
        chk("sw_c1_addr", 64'(jtag_req_addr), 64'h10); chk("sw_c1_data", jtag_req_data, 64'hA0);
        chk("sw_c1_busy", 64'(busy), 64'd1);
        tick();
        #2; chk("sw_c2_rdy", 64'(req_rdy), 64'b10); chk("sw_c2_jvld", 64'(jtag_req_vld), 64'd0);
        tick(); req_vld[1] = 1'b0;
        #2; chk("sw_c3_jvld", 64'(jtag_req_vld), 64'd1); chk("sw_c3_addr", 64'(jtag_req_addr), 64'h20);
        chk("sw_c3_owner", 64'(owner), 64'd1);
        tick();
        #2; chk("sw_c4_busy", 64'(busy), 64'd0);
        tick();

        // read response routing
        set_req(1, 1'b1, 2'b00, 40'h30, 64'h0);
        #2; chk("rd_acc_rdy", 64'(req_rdy), 64'b10);
        tick(); req_vld[1] = 1'b0; set_req(0, 1'b1, 2'b01, 40'h40, 64'hC0);
        #2; chk("rd_iss_addr", 64'(jtag_req_addr), 64'h30); chk("rd_iss_op", 64'(jtag_req_op), 64'd0);
        chk("rd_iss_rdy", 64'(req_rdy), 64'b00);
        tick();
        for (int c = 0; c < 4; c++) begin
            #2; chk("rd_wait_rvld", 64'(rd_resp_vld), 64'b00); chk("rd_wait_rdy", 64'(req_rdy), 64'b00);
            chk("rd_wait_busy", 64'(busy), 64'd1);
            tick();
        end
        jtag_rd_resp_vld = 1'b1; jtag_rd_resp_data = 64'hDEAD_BEEF;
        for (int c = 0; c < 3; c++) begin
            #2; chk("rd_hold_rvld", 64'(rd_resp_vld), 64'b10); chk("rd_hold_jrdy", 64'(jtag_rd_resp_rdy), 64'd0);
            chk("rd_hold_data", rd_resp_data, 64'hDEAD_BEEF); chk("rd_hold_rdy", 64'(req_rdy), 64'b00);
            tick();
        end
        rd_resp_rdy = 2'b10;
        #2; chk("rd_hs_rvld", 64'(rd_resp_vld), 64'b10); chk("rd_hs_jrdy", 64'(jtag_rd_resp_rdy), 64'd1);
        chk("rd_hs_err", 64'(rd_resp_err), 64'd0);
        tick(); jtag_rd_resp_vld = 1'b0; rd_resp_rdy = '0;
        #2; chk("rd_next_rdy", 64'(req_rdy), 64'b01); chk("rd_no_stray", 64'(stray_resp), 64'd0);
        tick(); req_vld[0] = 1'b0;
        #2; chk("rd_next_addr", 64'(jtag_req_addr), 64'h40);
        tick();

`ifdef OURS_JTAG_REQ_ARB_TIMEOUT_EN
        // read with no engine response
        set_req(1, 1'b1, 2'b00, 40'h50, 64'h0);
        #2; chk("to_acc_rdy", 64'(req_rdy), 64'b10);
        tick(); req_vld[1] = 1'b0; jtag_rd_resp_data = 64'h1234_5678;
        #2; chk("to_iss_jvld", 64'(jtag_req_vld), 64'd1);
        tick();
        for (int c = 0; c < TO; c++) begin
            #2; chk("to_wait_rvld", 64'(rd_resp_vld), 64'b00); chk("to_wait_err", 64'(rd_resp_err), 64'd0);
            tick();
        end
        rd_resp_rdy = 2'b10;
        #2; chk("to_rvld", 64'(rd_resp_vld), 64'b10); chk("to_err", 64'(rd_resp_err), 64'd1);
        chk("to_data", rd_resp_data, 64'd0); chk("to_jrdy", 64'(jtag_rd_resp_rdy), 64'd0);
        tick(); rd_resp_rdy = '0; jtag_rd_resp_vld = 1'b1;
        #2; chk("to_late_jrdy", 64'(jtag_rd_resp_rdy), 64'd1); chk("to_late_rvld", 64'(rd_resp_vld), 64'b00);
        chk("to_late_pre", 64'(stray_resp), 64'd0);
        tick(); jtag_rd_resp_vld = 1'b0;
        #2; chk("to_late_stray", 64'(stray_resp), 64'd1);
        tick();
`endif

        // reset mid-read (req0 wins so rr_ptr becomes 1 before reset)
        set_req(0, 1'b1, 2'b00, 40'h60, 64'h0);
        #2; chk("mr_acc_rdy", 64'(req_rdy), 64'b01);
        tick(); req_vld[0] = 1'b0;
        #2; chk("mr_iss_jvld", 64'(jtag_req_vld), 64'd1);
        tick();
        #2; chk("mr_wait_busy", 64'(busy), 64'd1);
        tick(); rst = 1'b1;
        #2; chk("mr_busy", 64'(busy), 64'd0); chk("mr_rvld", 64'(rd_resp_vld), 64'b00);
        chk("mr_jvld", 64'(jtag_req_vld), 64'd0); chk("mr_stray", 64'(stray_resp), 64'd0);
        tick(); rst = 1'b0;
        set_req(0, 1'b1, 2'b01, 40'h70, 64'h0); set_req(1, 1'b1, 2'b01, 40'h80, 64'h0);
        #2; chk("mr_ptr0", 64'(req_rdy), 64'b01);
        tick(); req_vld = '0;
        tick();

        // stray response in IDLE
        jtag_rd_resp_vld = 1'b1; jtag_rd_resp_data = 64'h55;
        #2; chk("st_jrdy", 64'(jtag_rd_resp_rdy), 64'd1); chk("st_rvld", 64'(rd_resp_vld), 64'b00);
        tick(); jtag_rd_resp_vld = 1'b0;
        #2; chk("st_set", 64'(stray_resp), 64'd1);
        tick(); tick();
        #2; chk("st_sticky", 64'(stray_resp), 64'd1);
        tick();

        // random traffic against the behavioural model
        rst = 1'b1; req_vld = '0; rd_resp_rdy = '0; jtag_req_rdy = 1'b0; jtag_rd_resp_vld = 1'b0;
        tick(); rst = 1'b0;
        m_phase = 0; m_ptr = 0; m_owner = 0; m_wcnt = 0; m_to = 0; m_stray = 0;
        for (int i = 0; i < N; i++) pend[i] = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i]) begin
                    pend[i]   = 1;
                    p_op[i]   = OPW'($urandom_range(0, 3));
                    p_addr[i] = AW'({$urandom(), $urandom()});
                    p_data[i] = {$urandom(), $urandom()};
                end
                set_req(i, 1'($urandom_range(0, 1)), p_op[i], p_addr[i], p_data[i]);
            end
            jtag_req_rdy      = 1'($urandom_range(0, 1));
            jtag_rd_resp_vld  = ($urandom_range(0, 2) == 0);
            jtag_rd_resp_data = {$urandom(), $urandom()};
            rd_resp_rdy       = N'($urandom_range(0, (1 << N) - 1));
            #2;
            win = -1; e_rdy = '0;
            if (m_phase == 0)
                for (int k = 0; k < N; k++)
                    if (win < 0 && req_vld[(m_ptr + k) % N]) win = (m_ptr + k) % N;
            if (win >= 0) e_rdy[win] = 1'b1;
            e_rvld = '0; e_jrdy = 1'b1; e_err = 1'b0; e_rdata = jtag_rd_resp_data;
            if (m_phase == 2) begin
                if (m_to) begin
                    e_rvld[m_owner] = 1'b1; e_err = 1'b1; e_rdata = '0; e_jrdy = 1'b0;
                end else begin
                    e_rvld[m_owner] = jtag_rd_resp_vld; e_jrdy = rd_resp_rdy[m_owner];
                end
            end
            chk("rnd_rdy", 64'(req_rdy), 64'(e_rdy));
            chk("rnd_jvld", 64'(jtag_req_vld), 64'(m_phase == 1));
            chk("rnd_busy", 64'(busy), 64'(m_phase != 0));
            chk("rnd_owner", 64'(owner), 64'(m_owner));
            chk("rnd_stray", 64'(stray_resp), 64'(m_stray));
            chk("rnd_rvld", 64'(rd_resp_vld), 64'(e_rvld));
            chk("rnd_jrdy", 64'(jtag_rd_resp_rdy), 64'(e_jrdy));
            chk("rnd_err", 64'(rd_resp_err), 64'(e_err));
            if (m_phase == 1) begin
                chk("rnd_jop", 64'(jtag_req_op), 64'(m_op));
                chk("rnd_jaddr", 64'(jtag_req_addr), 64'(m_addr));
                chk("rnd_jdata", jtag_req_data, m_data);
            end
            if (m_phase == 2) chk("rnd_rdata", rd_resp_data, e_rdata);
            // advance model by one clock
            if (m_phase != 2 && jtag_rd_resp_vld) m_stray = 1;
            case (m_phase)
                0: if (win >= 0) begin
                    m_owner = win; m_ptr = (win + 1) % N;
                    m_op = p_op[win]; m_addr = p_addr[win]; m_data = p_data[win];
                    pend[win] = 0; m_phase = 1;
                end
                1: if (jtag_req_rdy) begin
                    m_phase = m_op[0] ? 0 : 2; m_wcnt = 0; m_to = 0;
                end
                default: begin
                    if (m_to) begin
                        if (rd_resp_rdy[m_owner]) begin m_phase = 0; m_to = 0; end
                    end else if (jtag_rd_resp_vld && rd_resp_rdy[m_owner]) begin
                        m_phase = 0;
                    end else begin
                        if (TO_EN && m_wcnt == TO - 1) m_to = 1;
                        m_wcnt++;
                    end
                end
            endcase
            tick();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
